s_p: RTL and testbench

- Serial-to-parallel converter at the FFT input. Collects a 16-sample serial frame, one complex sample per cycle, and presents it to the radix-4 datapath as four 4-lane words.
- Lane packing matches the FFT output side: lane j of beat k carries sample 4j+k.
- Ping-pong frame buffer: the next frame is written while the previous one drains, so input streams without gaps.

---
 rtl/s_p_if.sv | 22 ++
 rtl/s_p.sv | 92 +++++++++
 tb/tb_s_p.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/s_p_if.sv
// Stream interface of the FFT-input serial-to-parallel converter.
// The source (master) drives serial samples. The converter (slave) returns 4-lane beats.
interface s_p_if #(
  parameter int DATA_W = 34
);
  logic [DATA_W-1:0]   data_in;
  logic                in_valid;
  logic                in_sof;
  logic [4*DATA_W-1:0] data_out;
  logic                out_valid;
  logic                out_sof;

  modport master (
    output data_in, in_valid, in_sof,
    input  data_out, out_valid, out_sof
  );

  modport slave (
    input  data_in, in_valid, in_sof,
    output data_out, out_valid, out_sof
  );
endinterface

// File: rtl/s_p.sv
// Serial-to-parallel converter: 16-sample frames become four 4-lane beats through a ping-pong buffer (S_P_BITREV_EN enables bit-reversed placement).
// Latency: the first beat is registered one edge after sample 15 is written. Four beats follow back-to-back.
// Backpressure: none. A frame (16 cycles or more) always outlasts a drain (4 cycles).
module s_p #(
  parameter int DATA_W  = 34,
  parameter int FRAME_N = 16,
  parameter int LANES   = 4
) (
  input  logic clk,
  input  logic rst_n,
  s_p_if.slave bus
);
  localparam int AW    = $clog2(FRAME_N);
  localparam int BEATS = FRAME_N / LANES;
  localparam int BW    = $clog2(BEATS);

  logic [DATA_W-1:0]       mem [2][FRAME_N];
  logic [AW-1:0]           wr_idx;
  logic [AW-1:0]           addr;
  logic [AW-1:0]           waddr;
  logic                    wr_bank;
  logic                    rd_bank;
  logic                    rd_busy;
  logic [BW-1:0]           rd_beat;
  logic                    frame_done;
  logic [LANES*DATA_W-1:0] data_out_q;
  logic                    out_valid_q;
  logic                    out_sof_q;

  // A start-of-frame forces index 0, which also drops any partial frame.
  assign addr       = bus.in_sof ? '0 : wr_idx;
  assign frame_done = bus.in_valid && (addr == AW'(FRAME_N - 1));

`ifdef S_P_BITREV_EN
  assign waddr = {addr[0], addr[1], addr[2], addr[3]};
`else
  assign waddr = addr;
`endif

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      mem[wr_bank][waddr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_busy <= 1'b0;
      rd_beat <= '0;
    end else begin
      if (bus.in_valid) begin
        wr_idx <= addr + AW'(1);
      end
      if (frame_done) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
        rd_busy <= 1'b1;
        rd_beat <= '0;
      end else if (rd_busy) begin
        rd_beat <= rd_beat + BW'(1);
        if (rd_beat == BW'(BEATS - 1)) begin
          rd_busy <= 1'b0;
        end
      end
    end
  end

  // Lane j of beat k carries sample LANES*... i.e. index j*BEATS + k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end else if (rd_busy) begin
      for (int j = 0; j < LANES; j++) begin
        data_out_q[j*DATA_W +: DATA_W] <= mem[rd_bank][AW'(j*BEATS) + AW'(rd_beat)];
      end
      out_valid_q <= 1'b1;
      out_sof_q   <= (rd_beat == '0);
    end else begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
endmodule

// File: tb/tb_s_p.sv
// Scoreboard bench for s_p: a frame-level model predicts beats and their cycle, and a monitor checks them.
module tb_s_p;
  localparam int W = 34;

  typedef struct {
    logic [4*W-1:0] dat;
    logic           sof;
    int             cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  exp_t   q[$];
  logic [W-1:0] part[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  s_p_if #(.DATA_W(W)) bus();

  s_p #(.DATA_W(W), .FRAME_N(16), .LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Buffer position of the i-th sample of a frame.
  function automatic int place(input int i);
`ifdef S_P_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) begin
      if (i[b]) r = r + (1 << (3 - b));
    end
    return r;
`else
    return i;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0] buff [16];
    exp_t e;
    if (!rst_n) begin
      q.delete();
      part.delete();
    end else begin
      cyc++;
      if (bus.in_valid) begin
        if (bus.in_sof) part.delete();
        part.push_back(bus.data_in);
        if (part.size() == 16) begin
          for (int i = 0; i < 16; i++) buff[place(i)] = part[i];
          for (int k = 0; k < 4; k++) begin
            e.dat = '0;
            for (int j = 0; j < 4; j++) e.dat[j*W +: W] = buff[4*j + k];
            e.sof = (k == 0);
            e.cyc = cyc + 1 + k;
            q.push_back(e);
          end
          part.delete();
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      chk("valid_in_reset", {135'd0, bus.out_valid}, '0);
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: actual=%h required=none", bus.data_out);
      end else begin
        e = q.pop_front();
        chk("beat_data", bus.data_out, e.dat);
        chk("beat_sof", {135'd0, bus.out_sof}, {135'd0, e.sof});
        chk("beat_time", 136'(cyc), 136'(e.cyc));
      end
    end else begin
      chk("sof_without_valid", {135'd0, bus.out_sof}, '0);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_beat: actual=none required=%h", e.dat);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic s);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.in_sof   = s;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [W-1:0] base);
    for (int i = 0; i < 16; i++) send(base + W'(i), i == 0);
  endtask

  initial begin
    bus.data_in  = '0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {135'd0, bus.out_valid}, '0);
    chk("reset_sof", {135'd0, bus.out_sof}, '0);
    chk("reset_data", bus.data_out, '0);
    rst_n = 1'b1;
    idle(2);

    // single frame
    frame(W'(0));
    idle(8);

    // back-to-back frames through the ping-pong buffer
    for (int i = 0; i < 32; i++) send(W'(i), i == 0);
    idle(8);

    // in_valid gaps
    for (int i = 0; i < 16; i++) begin
      send(W'(i), i == 0);
      idle(1);
    end
    idle(8);

    // resync discards a partial frame
    for (int i = 0; i < 7; i++) send(W'(32'h200 + i), i == 0);
    for (int i = 0; i < 16; i++) send(W'(32'h100 + i), i == 0);
    idle(8);

    // reset while beat 2 is on the output
    frame(W'(32'h300));
    idle(3);
    chk("drain_active", {135'd0, bus.out_valid}, {135'd0, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {135'd0, bus.out_valid}, '0);
    chk("abort_sof", {135'd0, bus.out_sof}, '0);
    chk("abort_data", bus.data_out, '0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    frame(W'(32'h40));
    idle(8);

    // random traffic with occasional resyncs
    repeat (400) begin
      if ($urandom_range(0, 3) != 0)
        send(W'({$urandom(), $urandom()}), $urandom_range(0, 19) == 0);
      else
        idle(1);
    end
    idle(10);

    chk("queue_drained", 136'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
